affine_write_gen: RTL and testbench

//  Write-side counterpart of the 2D affine read address generator. Accepts a

---
 rtl/affine_write_gen.sv | 165 ++++++++++++++++
 tb/tb_affine_write_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/affine_write_gen.sv
// Write-side 2D affine address generator: each accepted stream beat is written to
// offset + x*x_stride + y*y_stride (x fastest), with a done pulse at end of frame.
module affine_write_gen #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] x_max,
  input  logic [ADDR_W-1:0] x_stride,
  input  logic [ADDR_W-1:0] y_max,
  input  logic [ADDR_W-1:0] y_stride,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_offset;
  logic [ADDR_W-1:0] r_x_max;
  logic [ADDR_W-1:0] r_x_stride;
  logic [ADDR_W-1:0] r_y_max;
  logic [ADDR_W-1:0] r_y_stride;
  logic [ADDR_W-1:0] r_x_cnt;
  logic [ADDR_W-1:0] r_y_cnt;
  logic [ADDR_W-1:0] r_x_acc;
  logic [ADDR_W-1:0] r_y_acc;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_start_ok;
  logic              w_zero_ext;
  logic              w_accept;
  logic              w_x_last;
  logic              w_y_last;
  logic              w_frame_last;
  logic [ADDR_W-1:0] w_beat_addr;

  // Extent check uses the live inputs: they are exactly what gets latched on this edge.
  assign w_start_ok   = (r_state == S_IDLE) && start;
  assign w_zero_ext   = (x_max == '0) || (y_max == '0);
  assign w_accept     = in_valid && (r_state == S_RUN);
  assign w_x_last     = (r_x_cnt == (r_x_max - ADDR_W'(1)));
  assign w_y_last     = (r_y_cnt == (r_y_max - ADDR_W'(1)));
  assign w_frame_last = w_accept && w_x_last && w_y_last;
  assign w_beat_addr  = r_offset + r_x_acc + r_y_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_zero_ext ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_frame_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset   <= '0;
      r_x_max    <= '0;
      r_x_stride <= '0;
      r_y_max    <= '0;
      r_y_stride <= '0;
    end else if (w_start_ok) begin
      r_offset   <= offset;
      r_x_max    <= x_max;
      r_x_stride <= x_stride;
      r_y_max    <= y_max;
      r_y_stride <= y_stride;
    end
  end

  // Raster walk: x wraps into y; both wrap to zero after the last beat of the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
      r_x_acc <= '0;
      r_y_acc <= '0;
    end else if (w_start_ok) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
      r_x_acc <= '0;
      r_y_acc <= '0;
    end else if (w_accept) begin
      if (!w_x_last) begin
        r_x_cnt <= r_x_cnt + ADDR_W'(1);
        r_x_acc <= r_x_acc + r_x_stride;
      end else begin
        r_x_cnt <= '0;
        r_x_acc <= '0;
        if (!w_y_last) begin
          r_y_cnt <= r_y_cnt + ADDR_W'(1);
          r_y_acc <= r_y_acc + r_y_stride;
        end else begin
          r_y_cnt <= '0;
          r_y_acc <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_accept;
      if (w_accept) begin
        r_mem_addr  <= w_beat_addr;
        r_mem_wdata <= in_data;
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_affine_write_gen.sv
// Scoreboard bench for affine_write_gen: expected writes come from a raster-order
// arithmetic model and are matched by a monitor whenever the DUT strobes mem_we.
module tb_affine_write_gen;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] offset = '0;
  logic [AW-1:0] x_max = '0;
  logic [AW-1:0] x_stride = '0;
  logic [AW-1:0] y_max = '0;
  logic [AW-1:0] y_stride = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          done;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    exp_done = 0;
  int    got_done = 0;

  always #5 clk = ~clk;

  affine_write_gen #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .offset(offset), .x_max(x_max),
    .x_stride(x_stride), .y_max(y_max), .y_stride(y_stride), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e.addr));
          chk("wr_data", 32'(mem_wdata), 32'(e.data));
          chk("done_with_last_write", 32'(done), 32'(e.last));
        end
      end
      if (done) got_done++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
  endtask

  // mode 0: valid held, 1: pattern 1,0,0 repeating, 2: random; poke>=0 pulses start at that cycle.
  task automatic run_frame(input int off, input int xm, input int xs, input int ym,
                           input int ys, input int mode, input int poke);
    logic [DW-1:0] d[$];
    beat_t b;
    int n;
    int k;
    int cyc;
    bit v;
    n = xm * ym;
    for (int y = 0; y < ym; y++) begin
      for (int x = 0; x < xm; x++) begin
        b.addr = AW'(off + x * xs + y * ys);
        b.data = DW'($urandom);
        b.last = (x == xm - 1) && (y == ym - 1);
        d.push_back(b.data);
        exp_q.push_back(b);
      end
    end
    exp_done++;
    offset = AW'(off); x_max = AW'(xm); x_stride = AW'(xs);
    y_max = AW'(ym); y_stride = AW'(ys);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (n == 0) begin
      chk("zero_busy", 32'(busy), 1);
      chk("zero_done", 32'(done), 1);
      chk("zero_in_ready", 32'(in_ready), 0);
      tick();
      chk("zero_idle_busy", 32'(busy), 0);
      chk("zero_idle_done", 32'(done), 0);
      chk("zero_idle_in_ready", 32'(in_ready), 0);
      return;
    end
    k = 0;
    cyc = 0;
    while (k < n) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (poke >= 0 && cyc == poke) begin
        start = 1'b1;
        offset = AW'($urandom); x_max = AW'($urandom_range(0, 3));
        x_stride = AW'($urandom); y_max = AW'($urandom_range(0, 3));
        y_stride = AW'($urandom);
      end
      in_valid = v;
      in_data = v ? d[k] : DW'($urandom);
      chk("frame_busy", 32'(busy), 1);
      chk("frame_in_ready", 32'(in_ready), 1);
      chk("frame_no_done", 32'(done), 0);
      tick();
      start = 1'b0;
      if (v) k++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("last_in_ready_low", 32'(in_ready), 0);
    chk("last_busy", 32'(busy), 1);
    chk("last_done", 32'(done), 1);
    chk("last_mem_we", 32'(mem_we), 1);
    tick();
    chk("after_busy", 32'(busy), 0);
    chk("after_done", 32'(done), 0);
    chk("after_mem_we", 32'(mem_we), 0);
  endtask

  // Two beats accepted, then reset lands while the second write is pending.
  task automatic abort_frame(input int off, input int xm, input int xs, input int ym, input int ys);
    beat_t b;
    b.addr = AW'(off);
    b.data = DW'($urandom);
    b.last = 1'b0;
    exp_q.push_back(b);
    offset = AW'(off); x_max = AW'(xm); x_stride = AW'(xs);
    y_max = AW'(ym); y_stride = AW'(ys);
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = b.data;
    tick();
    in_data = DW'($urandom);
    tick();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("abort_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_zero("abort_rel");
    tick();
    chk_all_zero("abort_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_zero("post_reset");
    tick();
    chk_all_zero("post_reset_clk");

    // Data offered while idle must be dropped.
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'($urandom);
      chk("idle_in_ready", 32'(in_ready), 0);
      tick();
    end
    in_valid = 1'b0;

    run_frame(100, 3, 1, 2, 10, 0, -1);
    run_frame(100, 3, 1, 2, 10, 1, -1);
    run_frame(200, 0, 1, 2, 10, 0, -1);
    run_frame(200, 5, 1, 0, 10, 0, -1);
    run_frame(16'hFFFE, 4, 1, 1, 0, 0, -1);
    abort_frame(300, 3, 1, 2, 10);
    run_frame(300, 3, 1, 2, 10, 0, -1);
    run_frame(50, 4, 2, 2, 20, 0, 3);
    run_frame(1000, 2, 7, 3, 33, 2, -1);
    run_frame(16'hFFF0, 3, 16'h8000, 2, 16'hFFFF, 0, -1);

    for (int f = 0; f < 25; f++) begin
      run_frame(int'($urandom_range(0, 65535)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 65535)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 65535)), int'($urandom_range(0, 2)),
                (f % 5 == 0) ? 1 : -1);
    end

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 0);
    chk("done_count", 32'(got_done), 32'(exp_done));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
